// File: rtl/fsmc_reg_bank.sv
// FSMC chip-select slot: 8 x 16-bit registers plus a TX stream FIFO fed by TXDATA writes.
// Latency: read data is registered one cycle into the access; a write lands one cycle after en_cs falls.
// Backpressure: tx_valid/tx_ready stream; a push into a full FIFO is dropped and sets sticky ovf.
module fsmc_reg_bank #(
    parameter logic [2:0] CS_ID   = 3'd1,
    parameter int         FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] module_in,
    input  logic [2:0]  cs_addr_latch,
    input  logic        en_cs,
    input  logic        fsmc_nwe,
    output logic [15:0] module_out,
    output logic        cs_state,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int                   DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW-1:0]   PTR_ONE   = 1;
    localparam logic [FIFO_AW:0]     LVL_ONE   = 1;
    localparam logic [FIFO_AW:0]     LVL_DEPTH = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEL, COMMIT, IGNORE} state_t;

    state_t             state, state_nxt;
    logic               en_cs_q, nwe_s1, nwe_s2;
    logic [2:0]         addr_q;
    logic               wr_seen;
    logic               ctrl_en;
    logic [15:0]        scratch;
    logic               ovf;
    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [15:0]        status, rd_mux;
    logic               en_rise, commit_wr, wr_ctrl, wr_status, wr_scratch;
    logic               push, pop, flush, full, empty, push_acc;

    assign en_rise    = en_cs & ~en_cs_q;
    assign commit_wr  = (state == COMMIT) && wr_seen;
    assign wr_ctrl    = commit_wr && (addr_q == 3'd0);
    assign wr_status  = commit_wr && (addr_q == 3'd1);
    assign push       = commit_wr && (addr_q == 3'd2);
    assign wr_scratch = commit_wr && (addr_q == 3'd3);
    assign flush      = wr_ctrl && module_in[1];
    assign full       = (level == LVL_DEPTH);
    assign empty      = (level == '0);
    assign tx_valid   = ~empty & ctrl_en;
    assign tx_data    = mem[rd_ptr];
    assign pop        = tx_valid & tx_ready;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign push_acc   = push && (!full || pop);
    assign status     = {8'h00, ovf, full, empty, 5'(level)};

    always_comb begin
        rd_mux = '0;
        case (addr_q)
            3'd0:    rd_mux = {15'd0, ctrl_en};
            3'd1:    rd_mux = status;
            3'd3:    rd_mux = scratch;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            en_cs_q <= 1'b0;
            nwe_s1  <= 1'b1;
            nwe_s2  <= 1'b1;
        end else begin
            state   <= state_nxt;
            en_cs_q <= en_cs;
            nwe_s1  <= fsmc_nwe;
            nwe_s2  <= nwe_s1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_rise) state_nxt = (cs_addr_latch == CS_ID) ? SEL : IGNORE;
            SEL:     if (!en_cs) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            IGNORE:  if (!en_cs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cs_state = (state == SEL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q     <= '0;
            wr_seen    <= 1'b0;
            module_out <= '0;
            ctrl_en    <= 1'b0;
            scratch    <= '0;
            ovf        <= 1'b0;
        end else begin
            if (state == IDLE && en_rise) begin
                addr_q  <= module_in[2:0];
                wr_seen <= 1'b0;
            end else if (state == SEL && !nwe_s2) begin
                wr_seen <= 1'b1;
            end
            // STATUS is live: the read mux is re-sampled every SEL cycle.
            module_out <= (state == SEL) ? rd_mux : '0;
            if (wr_ctrl)    ctrl_en <= module_in[0];
            if (wr_scratch) scratch <= module_in;
            if (wr_status && module_in[15]) ovf <= 1'b0;
            else if (push && !push_acc)     ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_acc) begin
                mem[wr_ptr] <= module_in;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_acc, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_fsmc_reg_bank.sv
// Bench for fsmc_reg_bank: bus accesses driven cycle by cycle, TX stream checked against a queue.
// Expected FIFO words are queued when a TXDATA write is issued and compared as each handshake occurs.
module tb_fsmc_reg_bank;
    logic        clk;
    logic        reset;
    logic [15:0] module_in;
    logic [2:0]  cs_addr_latch;
    logic        en_cs;
    logic        fsmc_nwe;
    logic [15:0] module_out;
    logic        cs_state;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [15:0] exp_q[$];

    fsmc_reg_bank #(.CS_ID(3'd1), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .module_in(module_in), .cs_addr_latch(cs_addr_latch),
        .en_cs(en_cs), .fsmc_nwe(fsmc_nwe), .module_out(module_out), .cs_state(cs_state),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream monitor: a handshake seen at the negedge is taken at the next posedge.
    always @(negedge clk) begin
        if (reset && tx_valid && tx_ready) begin
            logic [15:0] exp;
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %h, expected no word", tx_data);
            end else begin
                exp = exp_q.pop_front();
                if (tx_data !== exp) begin
                    errors++;
                    $display("FAIL tx_order: got %h, expected %h", tx_data, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_access(input logic [2:0] cs, input logic [2:0] addr, input logic wr,
                              input logic [15:0] data, input logic pulse,
                              output logic [15:0] rd, output logic cs2);
        tick();
        module_in     = {13'd0, addr};
        cs_addr_latch = cs;
        en_cs         = 1'b1;
        tick();
        tick();
        cs2 = cs_state;
        if (wr) begin
            fsmc_nwe  = 1'b0;
            module_in = data;
        end
        repeat (4) tick();
        rd       = module_out;
        fsmc_nwe = 1'b1;
        en_cs    = 1'b0;
        tick();
        if (pulse) tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
    endtask

    task automatic reg_write(input logic [2:0] addr, input logic [15:0] data);
        logic [15:0] rd;
        logic        cs2;
        bus_access(3'd1, addr, 1'b1, data, 1'b0, rd, cs2);
    endtask

    task automatic reg_read(input logic [2:0] addr, output logic [15:0] rd);
        logic cs2;
        bus_access(3'd1, addr, 1'b0, 16'h0000, 1'b0, rd, cs2);
    endtask

    task automatic tx_push(input logic [15:0] data, input logic pulse);
        logic [15:0] rd;
        logic        cs2;
        bus_access(3'd1, 3'd2, 1'b1, data, pulse, rd, cs2);
        if (exp_q.size() < 16) exp_q.push_back(data);
    endtask

    task automatic drain(input string name);
        tx_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        tick();
        tx_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout: %0d words left, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({module_out, cs_state, tx_valid, tx_data} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: out=%h cs=%b vld=%b dat=%h, expected all 0",
                     module_out, cs_state, tx_valid, tx_data);
        end
        reset = 1'b1;
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h0020) begin
            errors++;
            $display("FAIL reset_status: got %h, expected 0020", rd);
        end
    endtask

    task automatic test_scratch();
        logic [15:0] rd;
        logic        cs2;
        bus_access(3'd1, 3'd3, 1'b1, 16'hA5C3, 1'b0, rd, cs2);
        checks++;
        if (cs2 !== 1'b1) begin
            errors++;
            $display("FAIL scratch_cs_state: got %b, expected 1", cs2);
        end
        bus_access(3'd1, 3'd3, 1'b0, 16'h0000, 1'b0, rd, cs2);
        checks++;
        if (rd !== 16'hA5C3) begin
            errors++;
            $display("FAIL scratch_readback: got %h, expected a5c3", rd);
        end
        checks++;
        if (cs_state !== 1'b0) begin
            errors++;
            $display("FAIL scratch_cs_idle: got %b, expected 0", cs_state);
        end
    endtask

    task automatic test_cs_miss();
        logic [15:0] rd;
        logic        cs2;
        bus_access(3'd2, 3'd3, 1'b1, 16'h5A5A, 1'b0, rd, cs2);
        checks++;
        if (cs2 !== 1'b0 || rd !== 16'h0000) begin
            errors++;
            $display("FAIL cs_miss_outputs: cs=%b out=%h, expected cs=0 out=0000", cs2, rd);
        end
        reg_read(3'd3, rd);
        checks++;
        if (rd !== 16'hA5C3) begin
            errors++;
            $display("FAIL cs_miss_scratch: got %h, expected a5c3", rd);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [15:0] rd;
        tx_ready = 1'b0;
        reg_write(3'd0, 16'h0001);
        for (int i = 1; i <= 17; i++) tx_push(16'(i), 1'b0);
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h00D0) begin
            errors++;
            $display("FAIL fifo_full_status: got %h, expected 00d0", rd);
        end
        pops = 0;
        drain("fifo");
        checks++;
        if (pops != 16 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_pop_count: pops=%0d vld=%b, expected pops=16 vld=0", pops, tx_valid);
        end
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h00A0) begin
            errors++;
            $display("FAIL fifo_empty_status: got %h, expected 00a0", rd);
        end
    endtask

    task automatic test_ovf_clear();
        logic [15:0] rd;
        reg_write(3'd1, 16'h8000);
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h0020) begin
            errors++;
            $display("FAIL ovf_clear: got %h, expected 0020", rd);
        end
    endtask

    task automatic test_full_simultaneous();
        logic [15:0] rd;
        for (int i = 1; i <= 16; i++) tx_push(16'(i), 1'b0);
        pops = 0;
        tx_push(16'h0BEE, 1'b1);
        checks++;
        if (pops != 1) begin
            errors++;
            $display("FAIL simul_pop: pops=%0d, expected 1", pops);
        end
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h0050) begin
            errors++;
            $display("FAIL simul_status: got %h, expected 0050", rd);
        end
        drain("simul");
        checks++;
        if (pops != 17) begin
            errors++;
            $display("FAIL simul_pop_total: pops=%0d, expected 17", pops);
        end
    endtask

    task automatic test_flush_and_enable();
        logic [15:0] rd;
        for (int i = 0; i < 5; i++) tx_push(16'h0100 + 16'(i), 1'b0);
        reg_write(3'd0, 16'h0003);
        exp_q.delete();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b, expected 0", tx_valid);
        end
        reg_read(3'd1, rd);
        checks++;
        if (rd !== 16'h0020) begin
            errors++;
            $display("FAIL flush_status: got %h, expected 0020", rd);
        end
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL flush_ctrl: got %h, expected 0001", rd);
        end
        reg_write(3'd0, 16'h0000);
        tx_push(16'h7777, 1'b0);
        reg_read(3'd1, rd);
        checks++;
        if (tx_valid !== 1'b0 || rd !== 16'h0001) begin
            errors++;
            $display("FAIL en_gate: vld=%b status=%h, expected vld=0 status=0001", tx_valid, rd);
        end
        reg_write(3'd0, 16'h0001);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 16'h7777) begin
            errors++;
            $display("FAIL en_release: vld=%b dat=%h, expected vld=1 dat=7777", tx_valid, tx_data);
        end
        drain("enable");
    endtask

    task automatic test_reset_abort();
        logic [15:0] rd;
        reg_write(3'd3, 16'h1111);
        tick();
        module_in     = 16'h0003;
        cs_addr_latch = 3'd1;
        en_cs         = 1'b1;
        tick();
        tick();
        fsmc_nwe  = 1'b0;
        module_in = 16'h2222;
        repeat (5) tick();
        reset    = 1'b0;
        tick();
        en_cs    = 1'b0;
        fsmc_nwe = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (cs_state !== 1'b0 || module_out !== 16'h0000) begin
            errors++;
            $display("FAIL abort_outputs: cs=%b out=%h, expected 0", cs_state, module_out);
        end
        reg_read(3'd3, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL abort_scratch: got %h, expected 0000", rd);
        end
    endtask

    initial begin
        reset         = 1'b0;
        module_in     = '0;
        cs_addr_latch = '0;
        en_cs         = 1'b0;
        fsmc_nwe      = 1'b1;
        tx_ready      = 1'b0;
        test_reset();
        test_scratch();
        test_cs_miss();
        test_fifo_overflow();
        test_ovf_clear();
        test_full_simultaneous();
        test_flush_and_enable();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule
